load_store_unit: RTL and testbench

- Sits between the datapath's data-memory port and a synchronous data RAM (1-cycle read latency).
- Accepts one load/store request at a time and performs RV32I byte/halfword/word accesses.
- Generates byte enables, lane-shifts store data, and sign/zero-extends load data.
- Splits word-crossing (misaligned) accesses into two word accesses using a small state machine.

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_align.sv | 39 +++
 rtl/load_store_unit.sv | 144 ++++++++++++++
 tb/tb_load_store_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and decode helpers for the load/store unit.
package lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [3:0] MASK_BYTE = 4'b0001;
   localparam logic [3:0] MASK_HALF = 4'b0011;
   localparam logic [3:0] MASK_WORD = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC0 = 2'd1,
      ACC1 = 2'd2,
      DONE = 2'd3
   } lsu_state_t;

   // Unsigned loads have no store counterpart.
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      logic ok;
      case (f3)
         F3_LB, F3_LH, F3_LW: ok = 1'b1;
         F3_LBU, F3_LHU:      ok = ~we;
         default:             ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] size_mask(input logic [2:0] f3);
      logic [3:0] m;
      case (f3[1:0])
         2'b00:   m = MASK_BYTE;
         2'b01:   m = MASK_HALF;
         default: m = MASK_WORD;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment: store byte enables / data positioning and load extract / extend.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [63:0] rd_word,
   output logic [7:0]  be64,
   output logic [63:0] wd64,
   output logic        split,
   output logic [31:0] rdata
);

   logic [3:0]  mask_s;
   logic [31:0] wmask_s;
   logic [63:0] rd_shift_s;

   assign mask_s     = size_mask(funct3);
   assign wmask_s    = {{8{mask_s[3]}}, {8{mask_s[2]}}, {8{mask_s[1]}}, {8{mask_s[0]}}};
   assign be64       = {4'b0000, mask_s} << off;
   assign wd64       = {32'h0000_0000, wdata & wmask_s} << {off, 3'b000};
   assign split      = |be64[7:4];
   assign rd_shift_s = rd_word >> {off, 3'b000};

   // Pick the addressed bytes out of the assembled double word and extend them.
   always_comb begin
      rdata = 32'h0000_0000;
      case (funct3)
         F3_LB:   rdata = {{24{rd_shift_s[7]}}, rd_shift_s[7:0]};
         F3_LH:   rdata = {{16{rd_shift_s[15]}}, rd_shift_s[15:0]};
         F3_LW:   rdata = rd_shift_s[31:0];
         F3_LBU:  rdata = {24'h00_0000, rd_shift_s[7:0]};
         F3_LHU:  rdata = {16'h0000, rd_shift_s[15:0]};
         default: rdata = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a 1-cycle synchronous data RAM; word-crossing
// accesses are split into two consecutive word accesses.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DADDR = 10
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [2:0]       req_funct3,
   input  logic [DADDR-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             resp_valid,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             resp_err,
   output logic             mem_en,
   output logic             mem_we,
   output logic [3:0]       mem_be,
   output logic [DADDR-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata
);

   lsu_state_t       state_r, state_nxt_s;
   logic             we_r;
   logic [2:0]       f3_r;
   logic [DADDR-1:0] addr_r;
   logic [WIDTH-1:0] wdata_r;
   logic             err_r;
   logic [WIDTH-1:0] rd_lo_r;

   logic [7:0]         be64_s;
   logic [2*WIDTH-1:0] wd64_s;
   logic               split_s;
   logic [WIDTH-1:0]   ext_s;
   logic [2*WIDTH-1:0] rd_word_s;
   logic [DADDR-1:0]   word0_s;

   assign word0_s   = {addr_r[DADDR-1:2], 2'b00};
   // In DONE, mem_rdata holds the last word read; for split loads that is the high word.
   assign rd_word_s = split_s ? {mem_rdata, rd_lo_r} : {{WIDTH{1'b0}}, mem_rdata};

   lsu_align u_align (
      .funct3  (f3_r),
      .off     (addr_r[1:0]),
      .wdata   (wdata_r),
      .rd_word (rd_word_s),
      .be64    (be64_s),
      .wd64    (wd64_s),
      .split   (split_s),
      .rdata   (ext_s)
   );

   // State register and request latches.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         we_r    <= 1'b0;
         f3_r    <= 3'b000;
         addr_r  <= {DADDR{1'b0}};
         wdata_r <= {WIDTH{1'b0}};
         err_r   <= 1'b0;
         rd_lo_r <= {WIDTH{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         if (state_r == IDLE && req_valid) begin
            we_r    <= req_we;
            f3_r    <= req_funct3;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            err_r   <= ~f3_legal(req_we, req_funct3);
         end
         if (state_r == ACC1) begin
            rd_lo_r <= mem_rdata;
         end
      end
   end

   // Next-state and output decode; every output is a function of the state and latches.
   always_comb begin
      state_nxt_s = state_r;
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      resp_rdata  = {WIDTH{1'b0}};
      resp_err    = 1'b0;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_be      = 4'b0000;
      mem_addr    = {DADDR{1'b0}};
      mem_wdata   = {WIDTH{1'b0}};
      case (state_r)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (f3_legal(req_we, req_funct3)) begin
                  state_nxt_s = ACC0;
               end else begin
                  state_nxt_s = DONE;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACC0: begin
            mem_en    = 1'b1;
            mem_we    = we_r;
            mem_addr  = word0_s;
            mem_be    = be64_s[3:0];
            mem_wdata = wd64_s[WIDTH-1:0];
            if (split_s) begin
               state_nxt_s = ACC1;
            end else begin
               state_nxt_s = DONE;
            end
         end
         ACC1: begin
            mem_en      = 1'b1;
            mem_we      = we_r;
            mem_addr    = word0_s + {{(DADDR-3){1'b0}}, 3'b100};
            mem_be      = be64_s[7:4];
            mem_wdata   = wd64_s[2*WIDTH-1:WIDTH];
            state_nxt_s = DONE;
         end
         DONE: begin
            resp_valid = 1'b1;
            resp_err   = err_r;
            if (!we_r && !err_r) begin
               resp_rdata = ext_s;
            end else begin
               resp_rdata = {WIDTH{1'b0}};
            end
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// requests compared against a byte-addressed reference memory model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [9:0]  req_addr = 10'h000;
   logic [31:0] req_wdata = 32'h0000_0000;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_en;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   load_store_unit #(.WIDTH(32), .DADDR(10)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Synchronous data RAM with one-cycle read latency.
   logic [31:0] ram_w [0:255];
   logic        preload_en = 1'b1;
   always @(posedge clk) begin
      if (preload_en) begin
         for (int i = 0; i < 256; i++) ram_w[i] <= 32'h0000_0000;
         ram_w[0]   <= 32'h4433_2211;
         ram_w[1]   <= 32'h8877_6655;
         ram_w[255] <= 32'hDDCC_BBAA;
      end else if (mem_en) begin
         if (mem_we) begin
            for (int l = 0; l < 4; l++)
               if (mem_be[l]) ram_w[mem_addr[9:2]][8*l +: 8] <= mem_wdata[8*l +: 8];
         end else begin
            mem_rdata <= ram_w[mem_addr[9:2]];
         end
      end
   end

   // Reference model: byte memory plus expected transaction shape.
   logic [7:0]  ref_mem [0:1023];
   int          exp_n, exp_k;
   logic        exp_err;
   logic [31:0] exp_rdata;
   logic [9:0]  exp_addr [0:1];
   logic [3:0]  exp_be [0:1];
   logic [31:0] exp_wd [0:1];

   task automatic model_req(input logic we, input logic [2:0] f3, input int addr, input logic [31:0] wdata);
      int size, off, j, lane, b;
      bit sgn;
      logic [31:0] v;
      size = 0;
      sgn  = 1'b0;
      case (f3)
         3'd0: begin size = 1; sgn = 1'b1; end
         3'd1: begin size = 2; sgn = 1'b1; end
         3'd2: size = 4;
         3'd4: if (!we) size = 1;
         3'd5: if (!we) size = 2;
         default: size = 0;
      endcase
      off       = addr % 4;
      exp_err   = (size == 0);
      exp_rdata = 32'h0000_0000;
      exp_n     = 0;
      for (int w = 0; w < 2; w++) begin
         exp_be[w]   = 4'h0;
         exp_wd[w]   = 32'h0000_0000;
         exp_addr[w] = 10'((addr - off + 4 * w) % 1024);
      end
      v = 32'h0000_0000;
      for (int i = 0; i < size; i++) begin
         b    = (addr + i) % 1024;
         j    = (off + i) / 4;
         lane = (off + i) % 4;
         exp_be[j][lane] = 1'b1;
         exp_wd[j][8*lane +: 8] = wdata[8*i +: 8];
         if (j + 1 > exp_n) exp_n = j + 1;
         v = v | (32'(ref_mem[b]) << (8 * i));
         if (we) ref_mem[b] = wdata[8*i +: 8];
      end
      if (!we && size > 0) begin
         if (sgn && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
         exp_rdata = v;
      end
      exp_k = exp_err ? 1 : exp_n + 1;
   endtask

   // Observations of one request, filled by run_req.
   int          obs_k, obs_n, obs_busy_ready;
   logic        obs_ready0, obs_idle_ok, obs_err;
   logic [31:0] obs_rdata;
   logic [9:0]  obs_addr [0:3];
   logic [3:0]  obs_be [0:3];
   logic        obs_we [0:3];
   logic [31:0] obs_wd [0:3];

   task automatic run_req(input logic we, input logic [2:0] f3, input logic [9:0] addr, input logic [31:0] wdata);
      obs_k = 0; obs_n = 0; obs_busy_ready = 0; obs_err = 1'b0; obs_rdata = 32'h0000_0000;
      @(negedge clk);
      obs_ready0 = req_ready;
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      @(posedge clk);
      #1;
      // Garbage while busy: must be ignored, and must not be accepted in DONE.
      req_we = 1'($urandom_range(0, 1)); req_funct3 = 3'($urandom_range(0, 7));
      req_addr = 10'($urandom_range(0, 1023)); req_wdata = $urandom;
      for (int k = 1; k <= 8 && obs_k == 0; k++) begin
         @(negedge clk);
         if (req_ready) obs_busy_ready++;
         if (mem_en && obs_n < 4) begin
            obs_addr[obs_n] = mem_addr; obs_be[obs_n] = mem_be;
            obs_we[obs_n] = mem_we; obs_wd[obs_n] = mem_wdata;
            obs_n++;
         end
         if (resp_valid) begin
            obs_k = k; obs_rdata = resp_rdata; obs_err = resp_err;
         end
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      obs_idle_ok = req_ready && !mem_en && !resp_valid;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1 preload_en = 1'b0;
      n_checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_en !== 1'b0 || mem_we !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_ctrl got ready=%b resp=%b en=%b we=%b exp 1 0 0 0", req_ready, resp_valid, mem_en, mem_we);
      end
      n_checks++;
      if (mem_be !== 4'h0 || mem_addr !== 10'h000 || mem_wdata !== 32'h0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_data got be=%h addr=%h wd=%h rd=%h err=%b exp all 0", mem_be, mem_addr, mem_wdata, resp_rdata, resp_err);
      end
      @(negedge clk) reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1 || mem_en !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_release got ready=%b en=%b exp 1 0", req_ready, mem_en);
      end
   endtask

   task automatic test_load_word;
      model_req(1'b0, 3'd2, 0, 32'h0);
      run_req(1'b0, 3'd2, 10'h000, 32'h0);
      n_checks++;
      if (obs_k != 2 || obs_n != 1) begin
         n_errors++; $display("FAIL lw_timing got resp_k=%0d accesses=%0d exp 2 1", obs_k, obs_n);
      end
      n_checks++;
      if (obs_addr[0] !== 10'h000 || obs_be[0] !== 4'b1111 || obs_we[0] !== 1'b0) begin
         n_errors++; $display("FAIL lw_access got addr=%h be=%b we=%b exp 000 1111 0", obs_addr[0], obs_be[0], obs_we[0]);
      end
      n_checks++;
      if (obs_rdata !== 32'h4433_2211 || obs_busy_ready != 0 || !obs_ready0 || !obs_idle_ok) begin
         n_errors++; $display("FAIL lw_data got rd=%h busy_ready=%0d exp 44332211 0", obs_rdata, obs_busy_ready);
      end
   endtask

   task automatic test_byte_loads;
      logic [9:0]  a;
      logic [2:0]  f;
      logic [31:0] e;
      for (int i = 0; i < 4; i++) begin
         case (i)
            0:       begin a = 10'h003; f = 3'd0; e = 32'h0000_0044; end
            1:       begin a = 10'h007; f = 3'd0; e = 32'hFFFF_FF88; end
            2:       begin a = 10'h007; f = 3'd4; e = 32'h0000_0088; end
            default: begin a = 10'h006; f = 3'd5; e = 32'h0000_8877; end
         endcase
         model_req(1'b0, f, int'(a), 32'h0);
         run_req(1'b0, f, a, 32'h0);
         n_checks++;
         if (obs_rdata !== e || obs_k != 2) begin
            n_errors++; $display("FAIL subword_load%0d got rd=%h k=%0d exp %h 2", i, obs_rdata, obs_k, e);
         end
      end
   endtask

   task automatic test_split_load;
      model_req(1'b0, 3'd2, 2, 32'h0);
      run_req(1'b0, 3'd2, 10'h002, 32'h0);
      n_checks++;
      if (obs_k != 3 || obs_n != 2) begin
         n_errors++; $display("FAIL split_timing got resp_k=%0d accesses=%0d exp 3 2", obs_k, obs_n);
      end
      n_checks++;
      if (obs_addr[0] !== 10'h000 || obs_be[0] !== 4'b1100 || obs_addr[1] !== 10'h004 || obs_be[1] !== 4'b0011) begin
         n_errors++; $display("FAIL split_access got %h/%b %h/%b exp 000/1100 004/0011", obs_addr[0], obs_be[0], obs_addr[1], obs_be[1]);
      end
      n_checks++;
      if (obs_rdata !== 32'h6655_4433) begin
         n_errors++; $display("FAIL split_data got %h exp 66554433", obs_rdata);
      end
   endtask

   task automatic test_split_store;
      model_req(1'b1, 3'd1, 3, 32'h1234_BEEF);
      run_req(1'b1, 3'd1, 10'h003, 32'h1234_BEEF);
      n_checks++;
      if (obs_n != 2 || obs_k != 3 || obs_rdata !== 32'h0 || obs_err !== 1'b0) begin
         n_errors++; $display("FAIL sh_shape got n=%0d k=%0d rd=%h err=%b exp 2 3 0 0", obs_n, obs_k, obs_rdata, obs_err);
      end
      n_checks++;
      if (obs_addr[0] !== 10'h000 || obs_be[0] !== 4'b1000 || obs_wd[0][31:24] !== 8'hEF || obs_we[0] !== 1'b1) begin
         n_errors++; $display("FAIL sh_acc0 got %h/%b/%h exp 000/1000/EF", obs_addr[0], obs_be[0], obs_wd[0][31:24]);
      end
      n_checks++;
      if (obs_addr[1] !== 10'h004 || obs_be[1] !== 4'b0001 || obs_wd[1][7:0] !== 8'hBE || obs_we[1] !== 1'b1) begin
         n_errors++; $display("FAIL sh_acc1 got %h/%b/%h exp 004/0001/BE", obs_addr[1], obs_be[1], obs_wd[1][7:0]);
      end
      model_req(1'b0, 3'd2, 0, 32'h0);
      run_req(1'b0, 3'd2, 10'h000, 32'h0);
      n_checks++;
      if (obs_rdata !== 32'hEF33_2211) begin
         n_errors++; $display("FAIL sh_readback0 got %h exp EF332211", obs_rdata);
      end
      model_req(1'b0, 3'd2, 4, 32'h0);
      run_req(1'b0, 3'd2, 10'h004, 32'h0);
      n_checks++;
      if (obs_rdata !== 32'h8877_66BE) begin
         n_errors++; $display("FAIL sh_readback4 got %h exp 887766BE", obs_rdata);
      end
   endtask

   task automatic test_wrap;
      model_req(1'b0, 3'd2, 1022, 32'h0);
      run_req(1'b0, 3'd2, 10'h3FE, 32'h0);
      n_checks++;
      if (obs_n != 2 || obs_addr[0] !== 10'h3FC || obs_addr[1] !== 10'h000) begin
         n_errors++; $display("FAIL wrap_addr got n=%0d %h %h exp 2 3FC 000", obs_n, obs_addr[0], obs_addr[1]);
      end
      n_checks++;
      if (obs_rdata !== 32'h2211_DDCC) begin
         n_errors++; $display("FAIL wrap_data got %h exp 2211DDCC", obs_rdata);
      end
   endtask

   task automatic test_error;
      model_req(1'b0, 3'd3, 8, 32'h0);
      run_req(1'b0, 3'd3, 10'h008, 32'h0);
      n_checks++;
      if (obs_k != 1 || obs_n != 0 || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
         n_errors++; $display("FAIL err_f3_011 got k=%0d n=%0d err=%b rd=%h exp 1 0 1 0", obs_k, obs_n, obs_err, obs_rdata);
      end
      model_req(1'b1, 3'd4, 0, 32'hFFFF_FFFF);
      run_req(1'b1, 3'd4, 10'h000, 32'hFFFF_FFFF);
      n_checks++;
      if (obs_k != 1 || obs_n != 0 || obs_err !== 1'b1 || !obs_idle_ok) begin
         n_errors++; $display("FAIL err_store_unsigned got k=%0d n=%0d err=%b exp 1 0 1", obs_k, obs_n, obs_err);
      end
   endtask

   task automatic test_reset_mid;
      int bad;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 10'h002; req_wdata = 32'h0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (mem_en !== 1'b1) begin
         n_errors++; $display("FAIL rstmid_in_acc1 got en=%b exp 1", mem_en);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
         n_errors++; $display("FAIL rstmid_async got en=%b we=%b exp 0 0", mem_en, mem_we);
      end
      bad = 0;
      repeat (3) begin @(negedge clk); if (resp_valid) bad++; end
      reset = 1'b0;
      repeat (3) begin @(negedge clk); if (resp_valid || mem_en) bad++; end
      n_checks++;
      if (bad != 0 || req_ready !== 1'b1) begin
         n_errors++; $display("FAIL rstmid_discard got stray=%0d ready=%b exp 0 1", bad, req_ready);
      end
      model_req(1'b0, 3'd2, 4, 32'h0);
      run_req(1'b0, 3'd2, 10'h004, 32'h0);
      n_checks++;
      if (obs_rdata !== exp_rdata || obs_k != exp_k) begin
         n_errors++; $display("FAIL rstmid_after got rd=%h k=%0d exp %h %0d", obs_rdata, obs_k, exp_rdata, exp_k);
      end
   endtask

   task automatic test_random(input int n);
      logic        we;
      logic [2:0]  f3;
      logic [9:0]  a;
      logic [31:0] wd;
      for (int t = 0; t < n; t++) begin
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = (t % 4 == 0) ? 10'($urandom_range(1016, 1023)) : 10'($urandom_range(0, 1023));
         wd = $urandom;
         model_req(we, f3, int'(a), wd);
         run_req(we, f3, a, wd);
         n_checks++;
         if (obs_k != exp_k || obs_n != exp_n) begin
            n_errors++; $display("FAIL rand%0d_shape got k=%0d n=%0d exp %0d %0d", t, obs_k, obs_n, exp_k, exp_n);
         end
         for (int j = 0; j < exp_n && j < obs_n; j++) begin
            n_checks++;
            if (obs_addr[j] !== exp_addr[j] || obs_be[j] !== exp_be[j] || obs_we[j] !== we || obs_wd[j] !== exp_wd[j]) begin
               n_errors++;
               $display("FAIL rand%0d_acc%0d got %h/%b/%b/%h exp %h/%b/%b/%h", t, j, obs_addr[j], obs_be[j], obs_we[j], obs_wd[j],
                        exp_addr[j], exp_be[j], we, exp_wd[j]);
            end
         end
         n_checks++;
         if (obs_rdata !== exp_rdata || obs_err !== exp_err) begin
            n_errors++; $display("FAIL rand%0d_resp got rd=%h err=%b exp %h %b", t, obs_rdata, obs_err, exp_rdata, exp_err);
         end
         n_checks++;
         if (obs_busy_ready != 0 || obs_ready0 !== 1'b1 || obs_idle_ok !== 1'b1) begin
            n_errors++; $display("FAIL rand%0d_handshake got busy_ready=%0d ready0=%b idle_ok=%b exp 0 1 1", t, obs_busy_ready, obs_ready0, obs_idle_ok);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
      ref_mem[0] = 8'h11; ref_mem[1] = 8'h22; ref_mem[2] = 8'h33; ref_mem[3] = 8'h44;
      ref_mem[4] = 8'h55; ref_mem[5] = 8'h66; ref_mem[6] = 8'h77; ref_mem[7] = 8'h88;
      ref_mem[1020] = 8'hAA; ref_mem[1021] = 8'hBB; ref_mem[1022] = 8'hCC; ref_mem[1023] = 8'hDD;
      test_reset();
      test_load_word();
      test_byte_loads();
      test_split_load();
      test_split_store();
      test_wrap();
      test_error();
      test_reset_mid();
      test_random(60);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
